// File: rtl/ogege_pkg.sv
// Shared definitions for the ogege video pixel path: cursor register map,
// CTRL bit positions and the packed 4:4:4 colour type.
package ogege_pkg;

    localparam logic [2:0] CUR_COL     = 3'd0;
    localparam logic [2:0] CUR_ROW     = 3'd1;
    localparam logic [2:0] CUR_CTRL    = 3'd2;
    localparam logic [2:0] CUR_PERIOD  = 3'd3;
    localparam logic [2:0] CUR_COLOR_L = 3'd4;
    localparam logic [2:0] CUR_COLOR_H = 3'd5;
    localparam logic [2:0] CUR_STATUS  = 3'd6;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLINK  = 1;
    localparam int CTRL_BLOCK  = 2;
    localparam int CTRL_INVERT = 3;
    localparam int CTRL_W      = 4;

    // Character cells are 8x8 pixels.
    localparam int CELL_SHIFT = 3;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/cursor_overlay_if.sv
// 8-bit peripheral register bus shared by the text area and cursor overlay.
interface cursor_overlay_if;

    logic       i_stb;
    logic       i_we;
    logic [2:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_data_ready;

    modport master (
        output i_stb, i_we, i_addr, i_data,
        input  o_data, o_data_ready
    );

    modport slave (
        input  i_stb, i_we, i_addr, i_data,
        output o_data, o_data_ready
    );

endinterface

// File: rtl/cursor_blink.sv
// Cursor blink timer: counts frame ends and toggles the visible phase every
// max(period,1) frames while blinking is enabled.
module cursor_blink (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fe_i,
    input  logic       blink_en_i,
    input  logic [7:0] period_i,
    input  logic       clear_i,
    output logic       phase_o
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] eff;
    logic       phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        eff     = (period_i == 8'd0) ? 8'd1 : period_i;
        // A CTRL write restarts the blink so a freshly moved cursor shows at once.
        if (clear_i) begin
            cnt_d   = 8'd0;
            phase_d = 1'b1;
        end else if (fe_i) begin
            if (!blink_en_i) begin
                cnt_d   = 8'd0;
                phase_d = 1'b1;
            end else if (cnt_q >= eff - 8'd1) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/cursor_overlay.sv
// Final pixel stage ahead of the VGA pins: overlays a programmable, optionally
// blinking text cursor on the text colour and registers RGB plus syncs.
module cursor_overlay #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SYNC_IDLE  = 1,
    parameter int DEF_PERIOD = 30
) (
    input  logic        i_pix_clk,
    input  logic        i_rstn,
    cursor_overlay_if.slave bus,
    input  logic [9:0]  i_scan_column,
    input  logic [8:0]  i_scan_row,
    input  logic        i_de,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [11:0] i_color,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic        o_hsync,
    output logic        o_vsync
);

    import ogege_pkg::*;

    logic wr, rd, ctrl_wr, fe, vblank, phase, hit;

    logic [6:0]        col_sh_q, col_sh_d, col_act_q;
    logic [5:0]        row_sh_q, row_sh_d, row_act_q;
    logic [CTRL_W-1:0] ctrl_sh_q, ctrl_sh_d, ctrl_act_q;
    logic [7:0]        period_q, period_d;
    rgb12_t            color_q, color_d;

    logic [7:0] rdata;
    logic [7:0] rdata_q;
    logic       rdy_q;

    logic [9-CELL_SHIFT:0] cell_col;
    logic [8-CELL_SHIFT:0] cell_row;
    logic [CELL_SHIFT-1:0] cell_line;

    rgb12_t pix_d, rgb_q;
    logic   hs_q, vs_q;

    assign wr      = bus.i_stb & bus.i_we;
    assign rd      = bus.i_stb & ~bus.i_we;
    assign ctrl_wr = wr & (bus.i_addr == CUR_CTRL);
    assign fe      = i_de & (i_scan_column == 10'(H_ACTIVE - 1))
                          & (i_scan_row == 9'(V_ACTIVE - 1));
    assign vblank  = (i_scan_row >= 9'(V_ACTIVE));

    always_comb begin
        col_sh_d  = col_sh_q;
        row_sh_d  = row_sh_q;
        ctrl_sh_d = ctrl_sh_q;
        period_d  = period_q;
        color_d   = color_q;
        if (wr) begin
            case (bus.i_addr)
                CUR_COL:     col_sh_d       = bus.i_data[6:0];
                CUR_ROW:     row_sh_d       = bus.i_data[5:0];
                CUR_CTRL:    ctrl_sh_d      = bus.i_data[CTRL_W-1:0];
                CUR_PERIOD:  period_d       = bus.i_data;
                CUR_COLOR_L: color_d[7:0]   = bus.i_data;
                CUR_COLOR_H: color_d[11:8]  = bus.i_data[3:0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (bus.i_addr)
            CUR_COL:     rdata = {1'b0, col_sh_q};
            CUR_ROW:     rdata = {2'b00, row_sh_q};
            CUR_CTRL:    rdata = {{(8-CTRL_W){1'b0}}, ctrl_sh_q};
            CUR_PERIOD:  rdata = period_q;
            CUR_COLOR_L: rdata = color_q[7:0];
            CUR_COLOR_H: rdata = {4'h0, color_q[11:8]};
            CUR_STATUS:  rdata = {6'b000000, vblank, phase};
            default:     rdata = 8'h00;
        endcase
    end

    cursor_blink u_blink (
        .clk_i      (i_pix_clk),
        .rst_ni     (i_rstn),
        .fe_i       (fe),
        .blink_en_i (ctrl_act_q[CTRL_BLINK]),
        .period_i   (period_q),
        .clear_i    (ctrl_wr),
        .phase_o    (phase)
    );

    // Off-screen COL/ROW simply never match a displayed cell.
    assign cell_col  = i_scan_column[9:CELL_SHIFT];
    assign cell_row  = i_scan_row[8:CELL_SHIFT];
    assign cell_line = i_scan_row[CELL_SHIFT-1:0];

    assign hit = ctrl_act_q[CTRL_EN] & phase & i_de
               & (cell_col == col_act_q) & (cell_row == row_act_q)
               & (ctrl_act_q[CTRL_BLOCK] | (cell_line >= 3'd6));

    always_comb begin
        pix_d = '0;
        if (i_de) begin
            if (hit) begin
                pix_d = ctrl_act_q[CTRL_INVERT] ? ~i_color : color_q;
            end else begin
                pix_d = i_color;
            end
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_sh_q   <= '0;
            row_sh_q   <= '0;
            ctrl_sh_q  <= '0;
            period_q   <= 8'(DEF_PERIOD);
            color_q    <= 12'hFFF;
            col_act_q  <= '0;
            row_act_q  <= '0;
            ctrl_act_q <= '0;
            rdata_q    <= 8'h00;
            rdy_q      <= 1'b0;
            rgb_q      <= '0;
            hs_q       <= 1'(SYNC_IDLE);
            vs_q       <= 1'(SYNC_IDLE);
        end else begin
            col_sh_q  <= col_sh_d;
            row_sh_q  <= row_sh_d;
            ctrl_sh_q <= ctrl_sh_d;
            period_q  <= period_d;
            color_q   <= color_d;
            // Position/mode only change between frames, taking a same-cycle write.
            if (fe) begin
                col_act_q  <= col_sh_d;
                row_act_q  <= row_sh_d;
                ctrl_act_q <= ctrl_sh_d;
            end
            rdy_q <= rd;
            if (rd) begin
                rdata_q <= rdata;
            end
            rgb_q <= pix_d;
            hs_q  <= i_hsync;
            vs_q  <= i_vsync;
        end
    end

    assign bus.o_data       = rdata_q;
    assign bus.o_data_ready = rdy_q;
    assign o_r              = rgb_q[11:8];
    assign o_g              = rgb_q[7:4];
    assign o_b              = rgb_q[3:0];
    assign o_hsync          = hs_q;
    assign o_vsync          = vs_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Bench for cursor_overlay: directed scenarios plus random bus/pixel traffic,
// all compared against a frame-level behavioural model of the cursor.
module tb_cursor_overlay;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    cursor_overlay_if bus();

    logic [9:0]  col;
    logic [8:0]  row;
    logic        de, hs, vs;
    logic [11:0] color;
    logic [3:0]  o_r, o_g, o_b;
    logic        o_hs, o_vs;

    cursor_overlay dut (
        .i_pix_clk     (clk),
        .i_rstn        (rstn),
        .bus           (bus),
        .i_scan_column (col),
        .i_scan_row    (row),
        .i_de          (de),
        .i_hsync       (hs),
        .i_vsync       (vs),
        .i_color       (color),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_hsync       (o_hs),
        .o_vsync       (o_vs)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: shadow (sh_*), frame-latched (act_*), blink.
    int sh_col, sh_row, sh_ctrl, act_col, act_row, act_ctrl;
    int m_period, m_color, m_phase, m_cnt;
    logic [7:0] exp_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sh_col = 0; sh_row = 0; sh_ctrl = 0;
        act_col = 0; act_row = 0; act_ctrl = 0;
        m_period = 30; m_color = 'hFFF; m_phase = 1; m_cnt = 0;
        exp_data = 8'h00;
    endtask

    task automatic set_pix(input int c, input int r, input int clr);
        col   = 10'(c);
        row   = 9'(r);
        de    = (c < 640) && (r < 480);
        hs    = !(c >= 656 && c < 752);
        vs    = !(r >= 490 && r < 492);
        color = 12'(clr);
    endtask

    task automatic idle_pix();
        set_pix(700, 500, 0);
    endtask

    function automatic int reg_val(input int a, input int vbl);
        case (a)
            0: return sh_col;
            1: return sh_row;
            2: return sh_ctrl;
            3: return m_period;
            4: return m_color & 'hFF;
            5: return (m_color >> 8) & 'hF;
            6: return (vbl << 1) | m_phase;
            default: return 0;
        endcase
    endfunction

    // One pixel clock: predict outputs from the current inputs, advance the model, compare.
    task automatic step();
        bit wr, rd, fe, hit, ex_rdy;
        int ex_c, d, eff;
        wr  = bus.i_stb && bus.i_we;
        rd  = bus.i_stb && !bus.i_we;
        fe  = de && (col == 639) && (row == 479);
        hit = ((act_ctrl & 1) != 0) && (m_phase == 1) && de
              && (int'(col) / 8 == act_col) && (int'(row) / 8 == act_row)
              && (((act_ctrl & 4) != 0) || (int'(row) % 8 >= 6));
        if (!de)     ex_c = 0;
        else if (hit) ex_c = ((act_ctrl & 8) != 0) ? (~int'(color)) & 'hFFF : m_color;
        else         ex_c = int'(color);
        ex_rdy = rd;
        if (rd) exp_data = 8'(reg_val(int'(bus.i_addr), int'(row >= 480)));
        if (fe) begin
            if ((act_ctrl & 2) == 0) begin
                m_phase = 1; m_cnt = 0;
            end else begin
                eff = (m_period == 0) ? 1 : m_period;
                if (m_cnt >= eff - 1) begin m_cnt = 0; m_phase = 1 - m_phase; end
                else m_cnt++;
            end
        end
        if (wr) begin
            d = int'(bus.i_data);
            case (int'(bus.i_addr))
                0: sh_col = d & 'h7F;
                1: sh_row = d & 'h3F;
                2: begin sh_ctrl = d & 'hF; m_phase = 1; m_cnt = 0; end
                3: m_period = d;
                4: m_color = (m_color & 'hF00) | d;
                5: m_color = (m_color & 'h0FF) | ((d & 'hF) << 8);
                default: ;
            endcase
        end
        if (fe) begin
            act_col = sh_col; act_row = sh_row; act_ctrl = sh_ctrl;
        end
        @(posedge clk);
        #1;
        check_val("rgb", {o_r, o_g, o_b}, ex_c);
        check_val("hsync", o_hs, hs);
        check_val("vsync", o_vs, vs);
        check_val("data_ready", bus.o_data_ready, ex_rdy);
        check_val("rdata", bus.o_data, exp_data);
    endtask

    task automatic bus_wr(input int a, input int d);
        bus.i_stb = 1'b1; bus.i_we = 1'b1; bus.i_addr = 3'(a); bus.i_data = 8'(d);
        step();
        bus.i_stb = 1'b0; bus.i_we = 1'b0;
    endtask

    task automatic bus_rd(input int a);
        bus.i_stb = 1'b1; bus.i_we = 1'b0; bus.i_addr = 3'(a);
        step();
        bus.i_stb = 1'b0;
    endtask

    task automatic frame_end();
        set_pix(639, 479, int'($urandom_range(0, 4095)));
        step();
    endtask

    // Counts pixels whose output equals tgt although the input colour differs.
    task automatic scan_region(input int r0, input int r1, input int c0, input int c1,
                               input int tgt, output int cnt);
        int clr;
        cnt = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                do clr = int'($urandom_range(0, 4095)); while (clr == tgt);
                set_pix(c, r, clr);
                step();
                if (int'({o_r, o_g, o_b}) == tgt) cnt++;
            end
        end
    endtask

    initial begin
        int n, rr, cc, rb, a, d;
        int ph_seq[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int ph_fast[4] = '{1, 0, 1, 0};

        bus.i_stb = 1'b0; bus.i_we = 1'b0; bus.i_addr = 3'd0; bus.i_data = 8'h00;
        idle_pix();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rgb", {o_r, o_g, o_b}, 0);
        check_val("rst_hsync", o_hs, 1);
        check_val("rst_vsync", o_vs, 1);
        check_val("rst_rdy", bus.o_data_ready, 0);
        check_val("rst_data", bus.o_data, 0);
        rstn = 1'b1;
        bus_rd(3);
        check_val("rst_period", bus.o_data, 30);
        bus_rd(4);
        check_val("rst_color_l", bus.o_data, 'hFF);

        // Reset asserted mid-line while active video is flowing.
        set_pix(100, 50, 'hABC);
        hs = 1'b0; vs = 1'b0;
        step();
        #2 rstn = 1'b0;
        #1;
        check_val("midrst_rgb", {o_r, o_g, o_b}, 0);
        check_val("midrst_hsync", o_hs, 1);
        check_val("midrst_vsync", o_vs, 1);
        model_reset();
        @(posedge clk);
        #2 rstn = 1'b1;
        step();
        check_val("post_rst_rgb", {o_r, o_g, o_b}, 'hABC);

        // Block cursor at cell (5,2): invisible until the frame end.
        idle_pix();
        bus_wr(0, 5); bus_wr(1, 2); bus_wr(2, 'h05); bus_wr(4, 'hF0); bus_wr(5, 'h0);
        scan_region(14, 25, 32, 55, 'h0F0, n);
        check_val("block_before_fe", n, 0);
        frame_end();
        scan_region(14, 25, 32, 55, 'h0F0, n);
        check_val("block_pixels", n, 64);

        // Underline at cell (0,0), then inverted.
        idle_pix();
        bus_wr(2, 'h01); bus_wr(0, 0); bus_wr(1, 0);
        frame_end();
        scan_region(0, 9, 0, 15, 'h0F0, n);
        check_val("underline_pixels", n, 16);
        idle_pix();
        bus_wr(2, 'h09);
        frame_end();
        set_pix(3, 7, 'h123); step();
        check_val("invert_rgb", {o_r, o_g, o_b}, 'hEDC);
        set_pix(3, 5, 'h123); step();
        check_val("invert_above_rgb", {o_r, o_g, o_b}, 'h123);

        // Blink: period 2, then period 0.
        idle_pix();
        bus_wr(3, 2); bus_wr(2, 'h03);
        for (int k = 0; k < 8; k++) begin
            frame_end(); idle_pix(); bus_rd(6);
            check_val("phase_p2", bus.o_data[0], ph_seq[k]);
        end
        bus_wr(3, 0);
        for (int k = 0; k < 4; k++) begin
            frame_end(); idle_pix(); bus_rd(6);
            check_val("phase_p0", bus.o_data[0], ph_fast[k]);
        end

        // Read latency and hold.
        bus_wr(3, 'h7F);
        bus_rd(3);
        check_val("rd_period", bus.o_data, 'h7F);
        check_val("rd_ready", bus.o_data_ready, 1);
        step();
        check_val("rd_ready_drop", bus.o_data_ready, 0);
        check_val("rd_hold", bus.o_data, 'h7F);
        bus_rd(7);
        check_val("rd_addr7", bus.o_data, 0);

        // COL written on the exact frame-end cycle.
        bus_wr(2, 'h05); bus_wr(1, 0);
        frame_end();
        set_pix(639, 479, 'h555);
        bus.i_stb = 1'b1; bus.i_we = 1'b1; bus.i_addr = 3'd0; bus.i_data = 8'd9;
        step();
        bus.i_stb = 1'b0; bus.i_we = 1'b0;
        scan_region(7, 7, 64, 79, 'h0F0, n);
        check_val("fe_write_col9", n, 8);
        idle_pix();
        bus_wr(0, 100);
        frame_end();
        scan_region(0, 7, 0, 639, 'h0F0, n);
        check_val("col100_no_hit", n, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rr = int'($urandom_range(0, 99));
            if (rr < 8) begin
                set_pix(639, 479, int'($urandom_range(0, 4095)));
            end else if (rr < 55) begin
                cc = act_col * 8 + int'($urandom_range(0, 7));
                rb = act_row * 8 + int'($urandom_range(0, 7));
                set_pix(cc, rb, int'($urandom_range(0, 4095)));
            end else begin
                set_pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                        int'($urandom_range(0, 4095)));
            end
            rr = int'($urandom_range(0, 99));
            a  = int'($urandom_range(0, 7));
            if (rr < 15) begin
                if (a == 0)      d = int'($urandom_range(0, 85));
                else if (a == 1) d = int'($urandom_range(0, 63));
                else if (a == 3) d = int'($urandom_range(0, 3));
                else             d = int'($urandom_range(0, 255));
                bus.i_stb = 1'b1; bus.i_we = 1'b1; bus.i_addr = 3'(a); bus.i_data = 8'(d);
            end else if (rr < 25) begin
                bus.i_stb = 1'b1; bus.i_we = 1'b0; bus.i_addr = 3'(a);
                bus.i_data = 8'($urandom_range(0, 255));
            end else begin
                bus.i_stb = 1'b0; bus.i_we = 1'b0;
            end
            step();
        end
        bus.i_stb = 1'b0; bus.i_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
